arb_requester: RTL and testbench

Requester-side front end for the 4-way round-robin REQ/GNT arbiter. Each channel queues job tokens from local logic, raises `REQ` while work is pending, and counts a fixed burst of beats while granted. It then drops `REQ` for exactly one cycle so the arbiter can rotate. It sits between the client engines and the arbiter, one channel per arbiter port.

---
 rtl/arb_req_pkg.sv | 15 +
 rtl/arb_req_channel.sv | 78 +++++++
 rtl/arb_requester.sv | 41 ++++
 tb/tb_arb_requester.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_req_pkg.sv
// Shared types and default sizing for the arbiter requester front end.
package arb_req_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    XFER = 2'd2,
    REL  = 2'd3
  } ch_state_t;

  localparam int N_CH      = 4;
  localparam int CNT_W     = 3;
  localparam int BURST_LEN = 4;

endpackage

// File: rtl/arb_req_channel.sv
// One requester channel: job queue depth counter, REQ/GNT handshake FSM and
// burst beat counter.
module arb_req_channel #(
  parameter int CNT_W     = arb_req_pkg::CNT_W,
  parameter int BURST_LEN = arb_req_pkg::BURST_LEN
) (
  input  logic clk,
  input  logic rst,
  input  logic job_valid,
  output logic job_ready,
  output logic req,
  input  logic gnt,
  output logic beat_valid,
  output logic done,
  output logic busy
);
  import arb_req_pkg::*;

  // A single-beat burst still needs a one-bit counter so the compare is legal.
  localparam int BCW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BCW-1:0]   LAST_BEAT = BCW'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] PEND_MAX  = '1;

  ch_state_t        state_q, state_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic [BCW-1:0]   beat_q, beat_d;
  logic             accept, last_beat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if ((pend_q != '0) || accept) state_d = WAIT;
      WAIT: begin
        if (beat_valid) begin
          if (BURST_LEN > 1) state_d = XFER;
          else               state_d = REL;
        end
      end
      XFER: if (last_beat) state_d = REL;
      // Pending was already decremented by the done edge that entered REL.
      REL:  begin
        if (pend_q != '0) state_d = WAIT;
        else              state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req        = (state_q == WAIT) || (state_q == XFER);
    job_ready  = (pend_q != PEND_MAX);
    accept     = job_valid & job_ready;
    beat_valid = req & gnt;
    last_beat  = beat_valid && (beat_q == LAST_BEAT);
    done       = last_beat;
    busy       = (state_q != IDLE) || (pend_q != '0);
  end

  always_comb begin
    pend_d = pend_q + CNT_W'(accept) - CNT_W'(last_beat);
    beat_d = beat_q;
    if (last_beat)       beat_d = '0;
    else if (beat_valid) beat_d = beat_q + 1'b1;
  end

endmodule

// File: rtl/arb_requester.sv
// Requester-side front end for the round-robin REQ/GNT arbiter: one
// independent channel per arbiter port.
module arb_requester #(
  parameter int N_CH      = arb_req_pkg::N_CH,
  parameter int CNT_W     = arb_req_pkg::CNT_W,
  parameter int BURST_LEN = arb_req_pkg::BURST_LEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] job_valid,
  output logic [N_CH-1:0] job_ready,
  output logic [N_CH-1:0] REQ,
  input  logic [N_CH-1:0] GNT,
  output logic [N_CH-1:0] beat_valid,
  output logic [N_CH-1:0] done,
  output logic            busy
);
  import arb_req_pkg::*;

  logic [N_CH-1:0] ch_busy;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    arb_req_channel #(
      .CNT_W    (CNT_W),
      .BURST_LEN(BURST_LEN)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .job_valid (job_valid[i]),
      .job_ready (job_ready[i]),
      .req       (REQ[i]),
      .gnt       (GNT[i]),
      .beat_valid(beat_valid[i]),
      .done      (done[i]),
      .busy      (ch_busy[i])
    );
  end

  assign busy = |ch_busy;

endmodule

// File: tb/tb_arb_requester.sv
// Scoreboard bench for arb_requester: a job/beat counting reference model
// predicts every cycle's outputs; a negedge monitor pops and compares.
module tb_arb_requester;
  localparam int NC   = 4;
  localparam int BL   = 4;
  localparam int MAXP = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic [NC-1:0] job_valid, job_ready, REQ, GNT, beat_valid, done;
  logic          busy;

  arb_requester #(.N_CH(NC), .CNT_W(3), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
    .REQ(REQ), .GNT(GNT), .beat_valid(beat_valid), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NC-1:0] req;
    logic [NC-1:0] bv;
    logic [NC-1:0] dn;
    logic [NC-1:0] rdy;
    logic          busy;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e, last_e;
  int            checks = 0;
  int            errors = 0;
  // Reference model: jobs queued, beats already moved for the head job,
  // and cycles the channel must keep REQ low after finishing a job.
  int            m_pend[NC], m_beats[NC], m_gap[NC];
  logic [NC-1:0] cur_jv, cur_gnt;
  int            gmode, owner, last_own;
  int            dn_cnt[NC], bv_cnt[NC];
  bit            chk_overlap;

  task automatic check_v(input string name, input logic [NC-1:0] act, input logic [NC-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, expv);
    end
  endtask

  task automatic check_i(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, expv);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      m_pend[i] = 0; m_beats[i] = 0; m_gap[i] = 0;
    end
    owner = -1;
    last_own = NC - 1;
  endtask

  function automatic exp_t model_out(input logic [NC-1:0] g);
    exp_t e;
    e = '0;
    for (int i = 0; i < NC; i++) begin
      e.req[i] = (m_pend[i] > 0) && (m_gap[i] == 0);
      e.bv[i]  = e.req[i] && g[i];
      e.dn[i]  = e.bv[i] && (m_beats[i] == BL - 1);
      e.rdy[i] = (m_pend[i] < MAXP);
      if ((m_pend[i] > 0) || (m_gap[i] > 0)) e.busy = 1'b1;
    end
    return e;
  endfunction

  task automatic model_edge();
    exp_t e;
    bit   acc;
    e = model_out(cur_gnt);
    for (int i = 0; i < NC; i++) begin
      acc = cur_jv[i] && (m_pend[i] < MAXP);
      // A job arriving while the release cycle finds nothing queued waits one idle cycle.
      if (m_gap[i] > 0) m_gap[i] = (m_pend[i] == 0 && acc) ? 1 : 0;
      else if (e.dn[i]) m_gap[i] = 1;
      if (e.dn[i])      m_beats[i] = 0;
      else if (e.bv[i]) m_beats[i]++;
      m_pend[i] = m_pend[i] + int'(acc) - int'(e.dn[i]);
    end
  endtask

  // Registered round-robin arbiter: grant holds while the owner keeps requesting.
  task automatic rr_next(output logic [NC-1:0] g);
    int c;
    g = '0;
    if (owner >= 0 && last_e.req[owner]) g[owner] = 1'b1;
    else begin
      owner = -1;
      for (int k = 1; k <= NC; k++) begin
        c = (last_own + k) % NC;
        if (owner < 0 && last_e.req[c]) owner = c;
      end
      if (owner >= 0) begin
        g[owner] = 1'b1;
        last_own = owner;
      end
    end
  endtask

  function automatic logic [NC-1:0] rand_gnt();
    int            r;
    logic [NC-1:0] g;
    r = $urandom_range(0, NC + 1);
    g = '0;
    if (r < NC) g[r] = 1'b1;
    return g;
  endfunction

  function automatic logic [NC-1:0] rand_jv();
    logic [NC-1:0] j;
    for (int k = 0; k < NC; k++) j[k] = ($urandom_range(0, 3) == 0);
    return j;
  endfunction

  // rctl: 0 none, 1 assert rst mid-cycle, 2 release rst
  task automatic tick(input logic [NC-1:0] jv, input logic [NC-1:0] g, input int rctl = 0);
    logic [NC-1:0] gg;
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge();
    #1;
    if (gmode == 1) rr_next(gg);
    else            gg = g;
    cur_jv = jv; cur_gnt = gg;
    job_valid = jv; GNT = gg;
    if (rctl == 2) rst = 1'b0;
    if (rctl == 1) begin
      rst = 1'b1;
      model_reset();
    end
    last_e = model_out(gg);
    exp_q.push_back(last_e);
    if (rctl == 1) begin
      #1;
      check_v("async_rst_REQ", REQ, '0);
      check_v("async_rst_beat_valid", beat_valid, '0);
      check_v("async_rst_done", done, '0);
      check_v("async_rst_job_ready", job_ready, '1);
      check_v("async_rst_busy", {3'b0, busy}, '0);
    end
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check_v("REQ", REQ, mon_e.req);
      check_v("beat_valid", beat_valid, mon_e.bv);
      check_v("done", done, mon_e.dn);
      check_v("job_ready", job_ready, mon_e.rdy);
      check_v("busy", {3'b0, busy}, {3'b0, mon_e.busy});
      if (chk_overlap) check_i("beat_overlap", ($countones(beat_valid) <= 1) ? 1 : 0, 1);
      for (int i = 0; i < NC; i++) begin
        dn_cnt[i] += int'(done[i]);
        bv_cnt[i] += int'(beat_valid[i]);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, b0, tot;
    int rc;
    rst = 1'b1; job_valid = '0; GNT = '0; cur_jv = '0; cur_gnt = '0;
    gmode = 0; chk_overlap = 0; last_e = '0;
    model_reset();
    for (int i = 0; i < NC; i++) begin dn_cnt[i] = 0; bv_cnt[i] = 0; end
    #2;
    check_v("reset_REQ", REQ, '0);
    check_v("reset_job_ready", job_ready, '1);
    check_v("reset_busy", {3'b0, busy}, '0);
    check_v("reset_beat_valid", beat_valid, '0);
    @(posedge clk); #1; rst = 1'b0;
    for (int k = 0; k < 3; k++) tick('0, '0);

    // single job on ch3, grant tied high from the cycle after REQ rises
    d0 = dn_cnt[3]; b0 = bv_cnt[3];
    tick(4'b1000, '0);
    tick('0, '0);
    for (int k = 0; k < 7; k++) tick('0, 4'b1000);
    settle();
    check_i("ch3_done_pulses", dn_cnt[3] - d0, 1);
    check_i("ch3_beats", bv_cnt[3] - b0, 4);

    // two queued jobs on ch1 with grant held
    d0 = dn_cnt[1]; b0 = bv_cnt[1];
    tick(4'b0010, '0);
    tick(4'b0010, '0);
    for (int k = 0; k < 14; k++) tick('0, 4'b0010);
    settle();
    check_i("ch1_done_pulses", dn_cnt[1] - d0, 2);
    check_i("ch1_beats", bv_cnt[1] - b0, 8);

    // grant gap on ch2 after the second beat
    d0 = dn_cnt[2]; b0 = bv_cnt[2];
    tick(4'b0100, '0);
    tick('0, '0);
    tick('0, 4'b0100); tick('0, 4'b0100);
    tick('0, '0); tick('0, '0);
    for (int k = 0; k < 4; k++) tick('0, 4'b0100);
    tick('0, '0); tick('0, '0);
    settle();
    check_i("ch2_gap_done", dn_cnt[2] - d0, 1);
    check_i("ch2_gap_beats", bv_cnt[2] - b0, 4);

    // pending counter fill on ch0: the 8th pulse is dropped
    d0 = dn_cnt[0];
    for (int k = 0; k < 8; k++) tick(4'b0001, '0);
    tick('0, '0);
    settle();
    check_i("ch0_full_ready", int'(job_ready[0]), 0);
    for (int k = 0; k < 45; k++) tick('0, 4'b0001);
    settle();
    check_i("ch0_full_done", dn_cnt[0] - d0, 7);

    // all channels at once behind the round-robin arbiter
    gmode = 1; chk_overlap = 1;
    tot = 0;
    for (int i = 0; i < NC; i++) tot += dn_cnt[i];
    tick(4'b1111, '0);
    for (int k = 0; k < 30; k++) tick('0, '0);
    settle();
    d0 = 0;
    for (int i = 0; i < NC; i++) d0 += dn_cnt[i];
    check_i("rr_total_done", d0 - tot, 4);

    // reset in the middle of a ch2 burst drops the job silently
    d0 = dn_cnt[2];
    tick(4'b0100, '0);
    for (int k = 0; k < 3; k++) tick('0, '0);
    tick('0, '0, 1);
    tick('0, '0); tick('0, '0);
    tick('0, '0, 2);
    for (int k = 0; k < 6; k++) tick('0, '0);
    settle();
    check_i("rst_mid_burst_no_done", dn_cnt[2] - d0, 0);

    // randomized traffic: free-running grants, then the round-robin arbiter
    gmode = 0; chk_overlap = 0;
    for (int k = 0; k < 1500; k++) begin
      rc = ($urandom_range(0, 399) == 0) ? 1 : (rst ? 2 : 0);
      tick(rand_jv(), rand_gnt(), rc);
    end
    gmode = 1; chk_overlap = 1;
    for (int k = 0; k < 1500; k++) begin
      rc = ($urandom_range(0, 399) == 0) ? 1 : (rst ? 2 : 0);
      tick(rand_jv(), '0, rc);
    end
    if (rst) tick('0, '0, 2);
    tick('0, '0);
    settle();
    check_i("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
